// File: rtl/uart_rx.sv
// UART receive engine: 16x-oversampled 8N1/8E1/8O1 frame recovery with
// per-frame parity and framing error flags and a one-cycle valid strobe.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                  rx_meta, rx_s;
  logic [2:0]            state, state_nx;
  logic [TW-1:0]         tick_cnt, tick_nx;
  logic [BW-1:0]         bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] shift, shift_nx;
  logic                  pbit, pbit_nx;
  logic                  armed, armed_nx;
  logic                  par_en_q, par_en_nx;
  logic                  par_odd_q, par_odd_nx;
  logic [DATA_WIDTH-1:0] rx_data_nx;
  logic                  rx_valid_nx, parity_err_nx, frame_err_nx;

  // Two-flop synchronizer; flops reset high so the idle line is not seen as a start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      pbit       <= 1'b0;
      armed      <= 1'b1;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      tick_cnt   <= tick_nx;
      bit_cnt    <= bit_nx;
      shift      <= shift_nx;
      pbit       <= pbit_nx;
      armed      <= armed_nx;
      par_en_q   <= par_en_nx;
      par_odd_q  <= par_odd_nx;
      rx_data    <= rx_data_nx;
      rx_valid   <= rx_valid_nx;
      parity_err <= parity_err_nx;
      frame_err  <= frame_err_nx;
      busy       <= (state_nx != IDLE);
    end
  end

  // Next-state and datapath decode; everything advances only on baud ticks.
  // armed blocks re-triggering on a held-low (break) line until a high sample is seen.
  always_comb begin
    state_nx      = state;
    tick_nx       = tick_cnt;
    bit_nx        = bit_cnt;
    shift_nx      = shift;
    pbit_nx       = pbit;
    armed_nx      = armed;
    par_en_nx     = par_en_q;
    par_odd_nx    = par_odd_q;
    rx_data_nx    = rx_data;
    rx_valid_nx   = 1'b0;
    parity_err_nx = parity_err;
    frame_err_nx  = frame_err;

    if (baud_tick) begin
      tick_nx = tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          tick_nx = '0;
          if (rx_s) begin
            armed_nx = 1'b1;
          end else if (armed) begin
            state_nx   = START;
            par_en_nx  = parity_en;
            par_odd_nx = parity_odd;
          end
        end
        START: begin
          if (tick_cnt == TICK_HALF) begin
            tick_nx = '0;
            if (!rx_s) begin
              state_nx = DATA;
              bit_nx   = '0;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx  = '0;
            shift_nx = {rx_s, shift[DATA_WIDTH-1:1]};
            bit_nx   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_nx = par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx  = '0;
            pbit_nx  = rx_s;
            state_nx = STOP;
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx       = '0;
            rx_data_nx    = shift;
            frame_err_nx  = ~rx_s;
            parity_err_nx = par_en_q & (^shift ^ pbit ^ par_odd_q);
            rx_valid_nx   = 1'b1;
            armed_nx      = rx_s;
            state_nx      = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          tick_nx  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table of single frames plus
// hand-written glitch, back-to-back, break and mid-frame reset sequences.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick = 1'b0;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stopb;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  int   n_vec = 0;
  int   n_err = 0;
  rec_t q[$];
  logic prev_valid = 1'b0;
  int   tdiv = 0;
  vec_t vt[8];

  always #5 clk = ~clk;

  // Baud tick every 4 clocks, driven on the falling edge
  always @(negedge clk) begin
    tdiv = (tdiv == 3) ? 0 : tdiv + 1;
    baud_tick = (tdiv == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture each valid strobe away from the active edge; it must never be two clocks wide
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      q.push_back('{data: rx_data, perr: parity_err, ferr: frame_err});
      chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
    end
    prev_valid = (rx_valid === 1'b1);
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stopb);
    rx = 1'b1;
  endtask

  task automatic check_one(input string tag, input logic [7:0] d, input logic perr, input logic ferr);
    chk({tag, "_count"}, 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      chk({tag, "_data"}, {24'd0, q[0].data}, {24'd0, d});
      chk({tag, "_perr"}, {31'd0, q[0].perr}, {31'd0, perr});
      chk({tag, "_ferr"}, {31'd0, q[0].ferr}, {31'd0, ferr});
    end
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    q.delete();
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        data   pen   podd  pbit  stop  exp    perr  ferr
    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[2] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
    vt[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[7] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};

    rst = 1'b0;
    rx = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_perr", {31'd0, parity_err}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    wait_ticks(16);

    // Single frames from the table
    for (int v = 0; v < 8; v++) begin
      parity_en = vt[v].pen;
      parity_odd = vt[v].podd;
      send_frame(vt[v].data, vt[v].pen, vt[v].pbit, vt[v].stopb);
      wait_ticks(16);
      check_one($sformatf("vec%0d", v), vt[v].exp_data, vt[v].exp_perr, vt[v].exp_ferr);
    end

    // Short low glitch is rejected at start-bit centre; previous outputs hold
    parity_en = 1'b0;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(8);
    chk("glitch_count", 32'(q.size()), 32'd0);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_data", {24'd0, rx_data}, 32'h80);
    chk("glitch_perr", {31'd0, parity_err}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);
    q.delete();
    wait_ticks(16);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    wait_ticks(16);
    chk("b2b_count", 32'(q.size()), 32'd3);
    if (q.size() == 3) begin
      chk("b2b_d0", {24'd0, q[0].data}, 32'h00);
      chk("b2b_d1", {24'd0, q[1].data}, 32'hFF);
      chk("b2b_d2", {24'd0, q[2].data}, 32'h55);
      chk("b2b_err", {30'd0, q[2].perr | q[1].perr | q[0].perr, q[2].ferr | q[1].ferr | q[0].ferr}, 32'd0);
    end
    q.delete();

    // Break: held-low line yields one zero frame with frame_err, then stays quiet
    rx = 1'b0;
    wait_ticks(16 * 14);
    check_one("break", 8'h00, 1'b0, 1'b1);
    rx = 1'b1;
    wait_ticks(16);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    wait_ticks(16);
    check_one("after_break", 8'h42, 1'b0, 1'b0);

    // Reset during bit 3 of 0xC3 discards the partial byte
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    wait_ticks(8);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_data", {24'd0, rx_data}, 32'd0);
    chk("midrst_count", 32'(q.size()), 32'd0);
    rx = 1'b1;
    rst = 1'b1;
    wait_ticks(32);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_ticks(16);
    check_one("post_rst", 8'h81, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
